// File: rtl/mips_pkg.sv
// Shared types and encodings for the 5-stage MIPS pipeline controller.
package mips_pkg;

  // Opcode encodings of the supported instructions
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BZ    = 6'h01;
  localparam logic [5:0] OP_JR    = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SUBI  = 6'h09;
  localparam logic [5:0] OP_MULI  = 6'h0a;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LDW   = 6'h23;
  localparam logic [5:0] OP_STW   = 6'h2b;
  localparam logic [5:0] OP_HALT  = 6'h3f;

  // Width of the destination index kept in a stage shadow
  localparam int SHADOW_AW = 5;

  typedef enum logic [2:0] {
    CLS_ALU_R  = 3'd0,
    CLS_ALU_I  = 3'd1,
    CLS_LOAD   = 3'd2,
    CLS_STORE  = 3'd3,
    CLS_BRANCH = 3'd4,
    CLS_HALT   = 3'd5
  } instr_cls_e;

  typedef struct packed {
    logic                 valid;
    instr_cls_e           cls;
    logic [SHADOW_AW-1:0] dest;
    logic                 writes;
  } stage_shadow_t;

  localparam stage_shadow_t SHADOW_NOP = '{valid: 1'b0, cls: CLS_ALU_R, dest: 5'd0, writes: 1'b0};

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/mips_hazard_unit.sv
// Combinational decode of the ID instruction plus load-use and forwarding compares.
module mips_hazard_unit
  import mips_pkg::*;
#(
  parameter int REG_AW       = 5,
  parameter bit R0_HARDWIRED = 1'b1
) (
  input  logic              id_valid,
  input  logic [5:0]        id_opcode,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  stage_shadow_t     ex_sh,
  input  stage_shadow_t     mem_sh,
  input  stage_shadow_t     wb_sh,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              ex_use_rs,
  input  logic              ex_use_rt,
  output stage_shadow_t     id_sh,
  output logic              id_use_rs,
  output logic              id_use_rt,
  output logic              load_use,
  output fwd_sel_e          fwd_a,
  output fwd_sel_e          fwd_b
);

  // Picks the operand source for one EX register read; the MEM result is newer than WB.
  function automatic fwd_sel_e fwd_pick(input logic use_src, input logic [REG_AW-1:0] src,
                                        input stage_shadow_t m_s, input stage_shadow_t w_s);
    fwd_sel_e sel;
    if (!use_src || (R0_HARDWIRED && (src == {REG_AW{1'b0}}))) begin
      sel = FWD_REG;
    end else if (m_s.valid && m_s.writes && (REG_AW'(m_s.dest) == src)) begin
      sel = FWD_MEM;
    end else if (w_s.valid && w_s.writes && (REG_AW'(w_s.dest) == src)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_REG;
    end
    return sel;
  endfunction

  // Decode class, destination and source usage of the instruction in ID.
  always_comb begin
    id_sh     = SHADOW_NOP;
    id_use_rs = 1'b0;
    id_use_rt = 1'b0;
    case (id_opcode)
      OP_RTYPE: begin
        id_sh.cls    = CLS_ALU_R;
        id_sh.dest   = SHADOW_AW'(id_rd);
        id_sh.writes = 1'b1;
        id_use_rs    = 1'b1;
        id_use_rt    = 1'b1;
      end
      OP_ADDI, OP_SUBI, OP_MULI, OP_ORI, OP_ANDI, OP_XORI: begin
        id_sh.cls    = CLS_ALU_I;
        id_sh.dest   = SHADOW_AW'(id_rt);
        id_sh.writes = 1'b1;
        id_use_rs    = 1'b1;
      end
      OP_LDW: begin
        id_sh.cls    = CLS_LOAD;
        id_sh.dest   = SHADOW_AW'(id_rt);
        id_sh.writes = 1'b1;
        id_use_rs    = 1'b1;
      end
      OP_STW: begin
        id_sh.cls = CLS_STORE;
        id_use_rs = 1'b1;
        id_use_rt = 1'b1;
      end
      OP_BZ, OP_JR: begin
        id_sh.cls = CLS_BRANCH;
        id_use_rs = 1'b1;
      end
      OP_BEQ: begin
        id_sh.cls = CLS_BRANCH;
        id_use_rs = 1'b1;
        id_use_rt = 1'b1;
      end
      OP_HALT: begin
        id_sh.cls = CLS_HALT;
      end
      default: begin
        // Unknown opcodes behave as a NOP: no destination, no sources.
        id_sh.cls = CLS_ALU_R;
      end
    endcase
    if (R0_HARDWIRED && (id_sh.dest == 5'd0)) begin
      id_sh.writes = 1'b0;
    end else begin
      id_sh.writes = id_sh.writes;
    end
    if (!id_valid) begin
      id_sh     = SHADOW_NOP;
      id_use_rs = 1'b0;
      id_use_rt = 1'b0;
    end else begin
      id_sh.valid = 1'b1;
    end
  end

  // Load-use: the load in EX produces a register the ID instruction reads.
  always_comb begin
    if (ex_sh.valid && (ex_sh.cls == CLS_LOAD) && ex_sh.writes) begin
      load_use = (id_use_rs && (REG_AW'(ex_sh.dest) == id_rs)) ||
                 (id_use_rt && (REG_AW'(ex_sh.dest) == id_rt));
    end else begin
      load_use = 1'b0;
    end
  end

  // Operand forwarding selects for the instruction currently in EX.
  always_comb begin
    fwd_a = fwd_pick(ex_use_rs, ex_rs, mem_sh, wb_sh);
    fwd_b = fwd_pick(ex_use_rt, ex_rt, mem_sh, wb_sh);
  end

endmodule

// File: rtl/mips_pipe_ctrl_chk.sv
// Protocol checks on the pipeline controller state.
module mips_pipe_ctrl_chk
  import mips_pkg::*;
(
  input logic        clk,
  input logic        rst,
  input ctrl_state_e state,
  input logic        ex_br_taken,
  input logic        pc_en
);

  // A branch cannot be in EX while draining, and a halted core never fetches.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!((state == ST_DRAIN) && ex_br_taken)) else $error("taken branch while draining");
      assert (!((state == ST_HALTED) && pc_en)) else $error("pc_en while halted");
    end
  end

endmodule

// File: rtl/mips_pipe_ctrl.sv
// Central pipeline controller: stage shadows, stall/flush sequencing, HALT drain, counters.
module mips_pipe_ctrl
  import mips_pkg::*;
#(
  parameter int REG_AW       = 5,
  parameter int CNT_W        = 32,
  parameter bit R0_HARDWIRED = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [5:0]        id_opcode,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              ex_br_taken,
  input  logic              mem_wait,
  output logic              pc_en,
  output logic              pc_sel_branch,
  output logic              if_id_en,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic              pipe_en,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_reg,
  output logic              halted,
  output logic [CNT_W-1:0]  perf_cycles,
  output logic [CNT_W-1:0]  perf_stalls,
  output logic [CNT_W-1:0]  perf_flushes,
  output logic [CNT_W-1:0]  perf_retired
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  stage_shadow_t     ex_sh_r, mem_sh_r, wb_sh_r, id_sh_s;
  logic [REG_AW-1:0] ex_rs_r, ex_rt_r;
  logic              ex_use_rs_r, ex_use_rt_r, id_use_rs_s, id_use_rt_s, load_use_s;
  fwd_sel_e          fwd_a_s, fwd_b_s;
  ctrl_state_e       state_r, next_state_s;
  logic              halted_r, halt_in_id_s;
  logic              pc_en_s, pc_sel_s, if_id_en_s, flush_s, bubble_s, pipe_en_s;
  logic              stall_evt_s, flush_evt_s, retire_evt_s;
  logic [CNT_W-1:0]  cycles_r, stalls_r, flushes_r, retired_r;

  mips_hazard_unit #(.REG_AW(REG_AW), .R0_HARDWIRED(R0_HARDWIRED)) u_hazard (
    .id_valid (id_valid),
    .id_opcode(id_opcode),
    .id_rs    (id_rs),
    .id_rt    (id_rt),
    .id_rd    (id_rd),
    .ex_sh    (ex_sh_r),
    .mem_sh   (mem_sh_r),
    .wb_sh    (wb_sh_r),
    .ex_rs    (ex_rs_r),
    .ex_rt    (ex_rt_r),
    .ex_use_rs(ex_use_rs_r),
    .ex_use_rt(ex_use_rt_r),
    .id_sh    (id_sh_s),
    .id_use_rs(id_use_rs_s),
    .id_use_rt(id_use_rt_s),
    .load_use (load_use_s),
    .fwd_a    (fwd_a_s),
    .fwd_b    (fwd_b_s)
  );

  mips_pipe_ctrl_chk u_chk (
    .clk        (clk),
    .rst        (rst),
    .state      (state_r),
    .ex_br_taken(ex_br_taken),
    .pc_en      (pc_en)
  );

  assign halt_in_id_s = id_sh_s.valid && (id_sh_s.cls == CLS_HALT);

  // Sequencing decision per cycle: priority is mem_wait, taken branch, load-use, HALT.
  always_comb begin
    pc_en_s      = 1'b0;
    pc_sel_s     = 1'b0;
    if_id_en_s   = 1'b0;
    flush_s      = 1'b0;
    bubble_s     = 1'b0;
    pipe_en_s    = 1'b0;
    next_state_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (mem_wait) begin
          next_state_s = ST_RUN;
        end else if (ex_br_taken) begin
          pc_en_s    = 1'b1;
          pc_sel_s   = 1'b1;
          if_id_en_s = 1'b1;
          flush_s    = 1'b1;
          bubble_s   = 1'b1;
          pipe_en_s  = 1'b1;
        end else if (load_use_s) begin
          bubble_s  = 1'b1;
          pipe_en_s = 1'b1;
        end else if (halt_in_id_s) begin
          // HALT advances into EX; fetch stops from this cycle on.
          pipe_en_s    = 1'b1;
          next_state_s = ST_DRAIN;
        end else begin
          pc_en_s    = 1'b1;
          if_id_en_s = 1'b1;
          pipe_en_s  = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (mem_wait) begin
          next_state_s = ST_DRAIN;
        end else begin
          // ID still holds the HALT, so only NOPs may enter EX.
          pipe_en_s = 1'b1;
          bubble_s  = 1'b1;
          if (wb_sh_r.valid && (wb_sh_r.cls == CLS_HALT)) begin
            next_state_s = ST_HALTED;
          end else begin
            next_state_s = ST_DRAIN;
          end
        end
      end
      ST_HALTED: begin
        next_state_s = ST_HALTED;
      end
      default: begin
        next_state_s = ST_RUN;
      end
    endcase
  end

  // Controller FSM and its registered halted flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_RUN;
      halted_r <= 1'b0;
    end else begin
      state_r  <= next_state_s;
      halted_r <= (next_state_s == ST_HALTED);
    end
  end

  // Stage shadows advance together whenever the back end is enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_sh_r     <= SHADOW_NOP;
      mem_sh_r    <= SHADOW_NOP;
      wb_sh_r     <= SHADOW_NOP;
      ex_rs_r     <= {REG_AW{1'b0}};
      ex_rt_r     <= {REG_AW{1'b0}};
      ex_use_rs_r <= 1'b0;
      ex_use_rt_r <= 1'b0;
    end else if (pipe_en_s) begin
      ex_sh_r     <= bubble_s ? SHADOW_NOP : id_sh_s;
      ex_rs_r     <= id_rs;
      ex_rt_r     <= id_rt;
      ex_use_rs_r <= bubble_s ? 1'b0 : id_use_rs_s;
      ex_use_rt_r <= bubble_s ? 1'b0 : id_use_rt_s;
      mem_sh_r    <= ex_sh_r;
      wb_sh_r     <= mem_sh_r;
    end
  end

  assign stall_evt_s  = (state_r == ST_RUN) && !mem_wait && !ex_br_taken && load_use_s;
  assign flush_evt_s  = (state_r == ST_RUN) && !mem_wait && ex_br_taken;
  assign retire_evt_s = pipe_en_s && wb_sh_r.valid && (wb_sh_r.cls != CLS_HALT);

  // Saturating performance counters, frozen once halted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycles_r  <= {CNT_W{1'b0}};
      stalls_r  <= {CNT_W{1'b0}};
      flushes_r <= {CNT_W{1'b0}};
      retired_r <= {CNT_W{1'b0}};
    end else if (state_r != ST_HALTED) begin
      cycles_r  <= sat_inc(cycles_r);
      stalls_r  <= stall_evt_s  ? sat_inc(stalls_r)  : stalls_r;
      flushes_r <= flush_evt_s  ? sat_inc(flushes_r) : flushes_r;
      retired_r <= retire_evt_s ? sat_inc(retired_r) : retired_r;
    end
  end

  assign pc_en         = pc_en_s & ~rst;
  assign pc_sel_branch = pc_sel_s & ~rst;
  assign if_id_en      = if_id_en_s & ~rst;
  assign if_id_flush   = flush_s & ~rst;
  assign id_ex_bubble  = bubble_s & ~rst;
  assign pipe_en       = pipe_en_s & ~rst;
  assign fwd_a         = rst ? 2'b00 : fwd_a_s;
  assign fwd_b         = rst ? 2'b00 : fwd_b_s;
  assign wb_en         = ~rst & wb_sh_r.valid & wb_sh_r.writes & ~mem_wait &
                         (state_r != ST_HALTED) &
                         (!R0_HARDWIRED || (wb_sh_r.dest != 5'd0));
  assign wb_reg        = rst ? {REG_AW{1'b0}} : REG_AW'(wb_sh_r.dest);
  assign halted        = halted_r;
  assign perf_cycles   = cycles_r;
  assign perf_stalls   = stalls_r;
  assign perf_flushes  = flushes_r;
  assign perf_retired  = retired_r;

endmodule

// File: tb/tb_mips_pipe_ctrl.sv
// Directed bench for mips_pipe_ctrl: hazards, forwarding, branch flush, HALT drain, mem_wait.
module tb_mips_pipe_ctrl;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ORI  = 6'h0d;
  localparam logic [5:0] OP_XORI = 6'h0e;
  localparam logic [5:0] OP_LDW  = 6'h23;
  localparam logic [5:0] OP_HALT = 6'h3f;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic [5:0]  id_opcode = 6'h00;
  logic [4:0]  id_rs = 5'd0, id_rt = 5'd0, id_rd = 5'd0;
  logic        ex_br_taken = 1'b0;
  logic        mem_wait = 1'b0;
  logic        pc_en, pc_sel_branch, if_id_en, if_id_flush, id_ex_bubble, pipe_en;
  logic [1:0]  fwd_a, fwd_b;
  logic        wb_en, halted;
  logic [4:0]  wb_reg;
  logic [31:0] perf_cycles, perf_stalls, perf_flushes, perf_retired;

  int n_checks = 0;
  int n_errors = 0;

  mips_pipe_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_br_taken(ex_br_taken),
    .mem_wait(mem_wait), .pc_en(pc_en), .pc_sel_branch(pc_sel_branch),
    .if_id_en(if_id_en), .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
    .pipe_en(pipe_en), .fwd_a(fwd_a), .fwd_b(fwd_b), .wb_en(wb_en), .wb_reg(wb_reg),
    .halted(halted), .perf_cycles(perf_cycles), .perf_stalls(perf_stalls),
    .perf_flushes(perf_flushes), .perf_retired(perf_retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [5:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd);
    id_valid  = v;
    id_opcode = op;
    id_rs     = rs;
    id_rt     = rt;
    id_rd     = rd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    ex_br_taken = 1'b0;
    mem_wait    = 1'b0;
    set_id(1'b0, OP_R, 5'd0, 5'd0, 5'd0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state while rst is held
    set_id(1'b0, OP_R, 5'd0, 5'd0, 5'd0);
    tick();
    chk("rst_pc_en", pc_en, 1'b0);
    chk("rst_if_id_en", if_id_en, 1'b0);
    chk("rst_pipe_en", pipe_en, 1'b0);
    chk("rst_wb_en", wb_en, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_fwd_a", fwd_a, 2'b00);
    chk("rst_cycles", perf_cycles, 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_pc_en", pc_en, 1'b1);
    chk("rel_if_id_en", if_id_en, 1'b1);

    // 1: ADD r3,r1,r2 ; ADD r4,r3,r1 -> EX/MEM forward
    do_reset();
    set_id(1'b1, OP_R, 5'd1, 5'd2, 5'd3);
    chk("t1_pc_en_a", pc_en, 1'b1);
    tick();
    set_id(1'b1, OP_R, 5'd3, 5'd1, 5'd4);
    chk("t1_no_stall", pc_en, 1'b1);
    chk("t1_no_bubble", id_ex_bubble, 1'b0);
    tick();
    set_id(1'b0, OP_R, 5'd0, 5'd0, 5'd0);
    chk("t1_fwd_a", fwd_a, 2'b01);
    chk("t1_fwd_b", fwd_b, 2'b00);
    tick();
    chk("t1_wb_en_3", wb_en, 1'b1);
    chk("t1_wb_reg_3", wb_reg, 5'd3);
    tick();
    chk("t1_wb_reg_4", wb_reg, 5'd4);
    chk("t1_stalls", perf_stalls, 32'd0);
    chk("t1_cycles", perf_cycles, 32'd4);

    // 2: LDW r5,0(r1) ; ADD r6,r5,r1 -> one stall then MEM/WB forward
    do_reset();
    set_id(1'b1, OP_LDW, 5'd1, 5'd5, 5'd0);
    tick();
    set_id(1'b1, OP_R, 5'd5, 5'd1, 5'd6);
    chk("t2_stall_pc_en", pc_en, 1'b0);
    chk("t2_stall_if_id_en", if_id_en, 1'b0);
    chk("t2_stall_bubble", id_ex_bubble, 1'b1);
    tick();
    chk("t2_resume_pc_en", pc_en, 1'b1);
    chk("t2_resume_bubble", id_ex_bubble, 1'b0);
    tick();
    set_id(1'b0, OP_R, 5'd0, 5'd0, 5'd0);
    chk("t2_fwd_a", fwd_a, 2'b10);
    chk("t2_wb_reg", wb_reg, 5'd5);
    chk("t2_stalls", perf_stalls, 32'd1);

    // 3: BEQ taken followed by two ADDs
    do_reset();
    set_id(1'b1, OP_BEQ, 5'd1, 5'd2, 5'd0);
    tick();
    set_id(1'b1, OP_R, 5'd1, 5'd2, 5'd7);
    ex_br_taken = 1'b1;
    #1;
    chk("t3_pc_sel", pc_sel_branch, 1'b1);
    chk("t3_flush", if_id_flush, 1'b1);
    chk("t3_bubble", id_ex_bubble, 1'b1);
    chk("t3_pc_en", pc_en, 1'b1);
    tick();
    ex_br_taken = 1'b0;
    set_id(1'b0, OP_R, 5'd0, 5'd0, 5'd0);
    for (int i = 0; i < 4; i++) begin
      chk("t3_no_wb", wb_en, 1'b0);
      tick();
    end
    chk("t3_flushes", perf_flushes, 32'd1);

    // 4: three ALU ops then HALT
    do_reset();
    set_id(1'b1, OP_ADDI, 5'd1, 5'd9, 5'd0);
    chk("t4_pc_en_run", pc_en, 1'b1);
    tick();
    set_id(1'b1, OP_ORI, 5'd1, 5'd10, 5'd0);
    tick();
    set_id(1'b1, OP_XORI, 5'd1, 5'd11, 5'd0);
    tick();
    set_id(1'b1, OP_HALT, 5'd0, 5'd0, 5'd0);
    chk("t4_halt_id_pc_en", pc_en, 1'b0);
    chk("t4_halt_id_if_id_en", if_id_en, 1'b0);
    tick();
    chk("t4_drain_pc_en", pc_en, 1'b0);
    tick();
    tick();
    chk("t4_halted_early", halted, 1'b0);
    tick();
    chk("t4_halted", halted, 1'b1);
    chk("t4_halted_pc_en", pc_en, 1'b0);
    chk("t4_retired", perf_retired, 32'd3);
    chk("t4_cycles", perf_cycles, 32'd7);
    tick();
    chk("t4_cycles_frozen", perf_cycles, 32'd7);

    // 5: mem_wait for 3 cycles during a load-use stall
    do_reset();
    set_id(1'b1, OP_R, 5'd1, 5'd1, 5'd2);
    tick();
    set_id(1'b1, OP_R, 5'd1, 5'd1, 5'd3);
    tick();
    set_id(1'b1, OP_LDW, 5'd1, 5'd5, 5'd0);
    tick();
    set_id(1'b1, OP_R, 5'd5, 5'd1, 5'd6);
    mem_wait = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("t5_wait_pc_en", pc_en, 1'b0);
      chk("t5_wait_if_id_en", if_id_en, 1'b0);
      chk("t5_wait_pipe_en", pipe_en, 1'b0);
      chk("t5_wait_bubble", id_ex_bubble, 1'b0);
      chk("t5_wait_wb_en", wb_en, 1'b0);
      tick();
    end
    mem_wait = 1'b0;
    #1;
    chk("t5_stall_bubble", id_ex_bubble, 1'b1);
    chk("t5_stall_pc_en", pc_en, 1'b0);
    chk("t5_frozen_wb_reg", wb_reg, 5'd2);
    chk("t5_wb_en", wb_en, 1'b1);
    tick();
    chk("t5_resume_pc_en", pc_en, 1'b1);
    chk("t5_resume_bubble", id_ex_bubble, 1'b0);
    chk("t5_wb_reg_3", wb_reg, 5'd3);
    tick();
    set_id(1'b0, OP_R, 5'd0, 5'd0, 5'd0);
    chk("t5_fwd_a", fwd_a, 2'b10);
    chk("t5_wb_reg_5", wb_reg, 5'd5);
    chk("t5_stalls", perf_stalls, 32'd1);

    // 6: $0 destination never forwards or writes; reset pulse while draining
    do_reset();
    set_id(1'b1, OP_R, 5'd1, 5'd2, 5'd0);
    tick();
    set_id(1'b1, OP_R, 5'd0, 5'd1, 5'd4);
    tick();
    set_id(1'b0, OP_R, 5'd0, 5'd0, 5'd0);
    chk("t6_fwd_a_r0", fwd_a, 2'b00);
    tick();
    chk("t6_wb_en_r0", wb_en, 1'b0);
    tick();
    chk("t6_wb_en_r4", wb_en, 1'b1);
    chk("t6_wb_reg_r4", wb_reg, 5'd4);
    set_id(1'b1, OP_HALT, 5'd0, 5'd0, 5'd0);
    tick();
    chk("t6_drain_pipe_en", pipe_en, 1'b1);
    chk("t6_drain_pc_en", pc_en, 1'b0);
    rst = 1'b1;
    #1;
    chk("t6_rst_pipe_en", pipe_en, 1'b0);
    chk("t6_rst_cycles", perf_cycles, 32'd0);
    chk("t6_rst_retired", perf_retired, 32'd0);
    chk("t6_rst_halted", halted, 1'b0);
    tick();
    rst = 1'b0;
    set_id(1'b0, OP_R, 5'd0, 5'd0, 5'd0);
    chk("t6_run_pc_en", pc_en, 1'b1);
    chk("t6_run_if_id_en", if_id_en, 1'b1);
    chk("t6_run_bubble", id_ex_bubble, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
